// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu
//   Execute-stage ALU with a multi-cycle multiply/divide unit.
//   The low opcodes form a single-cycle combinational ALU. MULT/MULTU/DIV/DIVU
//   run on an iterative shift-add / restoring-divide engine and write the
//   architectural HI/LO registers. MTHI/MTLO write HI/LO directly.
//
// Parameters
//   WIDTH        datapath width (even, >= 4)
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   a, b         operands (rs, rt/imm)
//   alucontrol   operation code
//   bne_flag     inverts the zero output for BNE
//   start        launch mult/div, or perform an MTHI/MTLO write
//   result       combinational result
//   zero         (result == 0) ^ bne_flag
//   busy         mult/div in progress
//   done         one-cycle pulse when a mult/div updates HI/LO
//   div_by_zero  sticky divide-by-zero flag, cleared by the next mult/div
//   hi, lo       architectural HI/LO registers
// -----------------------------------------------------------------------------
module alu_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alucontrol,
   input  logic             bne_flag,
   input  logic             start,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_NOR   = 4'b0100;
   localparam logic [3:0] OP_SLTU  = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MFHI  = 4'b1000;
   localparam logic [3:0] OP_MFLO  = 4'b1001;
   localparam logic [3:0] OP_MULT  = 4'b1010;
   localparam logic [3:0] OP_MULTU = 4'b1011;
   localparam logic [3:0] OP_DIV   = 4'b1100;
   localparam logic [3:0] OP_DIVU  = 4'b1101;
   localparam logic [3:0] OP_MTHI  = 4'b1110;
   localparam logic [3:0] OP_MTLO  = 4'b1111;

   localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

   // Two's-complement sign fixup helpers
   function automatic logic [WIDTH-1:0] fix_sign_w(input logic [WIDTH-1:0] v,
                                                   input logic neg);
      return neg ? (~v + ONE_W) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] fix_sign_2w(input logic [2*WIDTH-1:0] v,
                                                      input logic neg);
      return neg ? (~v + ONE_2W) : v;
   endfunction

   // ---------------------------------------------------------------------------
   // Combinational ALU
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             slt_bit;

   assign sum  = a + b;
   assign diff = a - b;
   // When signs differ the subtraction may overflow; a's sign alone decides.
   assign slt_bit = (a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1];

   always_comb begin
      result = '0;
      case (alucontrol)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_ADD:  result = sum;
         OP_XOR:  result = a ^ b;
         OP_NOR:  result = ~(a | b);
         OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SUB:  result = diff;
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt_bit};
         OP_MFHI: result = hi;
         OP_MFLO: result = lo;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0) ^ bne_flag;

   // ---------------------------------------------------------------------------
   // Multiply/divide control
   // ---------------------------------------------------------------------------
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          idle;
   logic          op_md;
   logic          op_mt;
   logic          accept_md;
   logic          accept_mt;

   assign idle  = (state == S_IDLE);
   assign busy  = ~idle;
   assign op_md = (alucontrol == OP_MULT) || (alucontrol == OP_MULTU) ||
                  (alucontrol == OP_DIV)  || (alucontrol == OP_DIVU);
   assign op_mt = (alucontrol == OP_MTHI) || (alucontrol == OP_MTLO);
   assign accept_md = start && idle && op_md;
   assign accept_mt = start && idle && op_mt;

   // Operand conditioning at accept: magnitudes and result signs
   logic             op_signed;
   logic             op_div;
   logic             a_neg;
   logic             b_neg;
   logic             b_is_zero;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   assign op_signed = (alucontrol == OP_MULT) || (alucontrol == OP_DIV);
   assign op_div    = (alucontrol == OP_DIV)  || (alucontrol == OP_DIVU);
   assign a_neg     = op_signed && a[WIDTH-1];
   assign b_neg     = op_signed && b[WIDTH-1];
   assign b_is_zero = (b == '0);
   assign a_mag     = fix_sign_w(a, a_neg);
   assign b_mag     = fix_sign_w(b, b_neg);

   // Datapath state: acc holds {upper, lower}. For multiply the lower half is
   // the multiplier shifting out and the upper half the partial product. For
   // divide the lower half is the dividend shifting in as quotient bits and
   // the upper half the partial remainder.
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mag_b;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               dbz_pend;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_up;
   logic [WIDTH-1:0]   div_trial;
   logic               div_ge;
   logic [2*WIDTH-1:0] acc_step;

   assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : '0)};
   // Shifted partial remainder needs one extra bit before the trial subtract.
   assign div_up    = acc[2*WIDTH-1:WIDTH-1];
   assign div_ge    = (div_up >= {1'b0, mag_b});
   // When div_ge the difference is below mag_b and fits in WIDTH bits.
   assign div_trial = div_up[WIDTH-1:0] - mag_b;

   always_comb begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
      if (is_div) begin
         acc_step = {(div_ge ? div_trial : div_up[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
      end
   end

   // Final sign fixup of the accumulated magnitudes
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   always_comb begin
      prod_fix = fix_sign_2w(acc, neg_q);
      fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = prod_fix[WIDTH-1:0];
      if (is_div) begin
         fix_hi = fix_sign_w(acc[2*WIDTH-1:WIDTH], neg_r);
         fix_lo = fix_sign_w(acc[WIDTH-1:0], neg_q);
      end
   end

   // --- stage: operand capture / iteration (data, no reset) ---
   always_ff @(posedge clk) begin
      if (accept_md) begin
         acc      <= {{WIDTH{1'b0}}, a_mag};
         mag_b    <= b_mag;
         is_div   <= op_div;
         // Divide by zero keeps the all-ones quotient unnegated.
         neg_q    <= (a_neg ^ b_neg) && !(op_div && b_is_zero);
         neg_r    <= a_neg;
         dbz_pend <= op_div && b_is_zero;
      end else if (state == S_CALC) begin
         acc <= acc_step;
      end
   end

   // --- stage: FSM and architectural registers ---
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept_md) begin
                  state       <= S_CALC;
                  cnt         <= '0;
                  div_by_zero <= 1'b0;
               end else if (accept_mt) begin
                  if (alucontrol == OP_MTHI) begin
                     hi <= a;
                  end else begin
                     lo <= a;
                  end
               end
            end
            S_CALC: begin
               if (cnt == CNT_LAST) begin
                  state <= S_FIX;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            S_FIX: begin
               hi          <= fix_hi;
               lo          <= fix_lo;
               div_by_zero <= dbz_pend;
               done        <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu
//   Self-checking bench for alu_mdu (WIDTH = 32): table-driven combinational
//   vectors, a scoreboard of expected HI/LO results for multiply/divide, and
//   hand-written sequences for start-while-busy, MTHI/MTLO, back-to-back and
//   mid-operation reset.
// -----------------------------------------------------------------------------
module tb_alu_mdu;

   localparam int W = 32;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_NOR   = 4'b0100;
   localparam logic [3:0] OP_SLTU  = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MFHI  = 4'b1000;
   localparam logic [3:0] OP_MFLO  = 4'b1001;
   localparam logic [3:0] OP_MULT  = 4'b1010;
   localparam logic [3:0] OP_MULTU = 4'b1011;
   localparam logic [3:0] OP_DIV   = 4'b1100;
   localparam logic [3:0] OP_DIVU  = 4'b1101;
   localparam logic [3:0] OP_MTHI  = 4'b1110;
   localparam logic [3:0] OP_MTLO  = 4'b1111;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   alucontrol;
   logic         bne_flag;
   logic         start;
   logic [W-1:0] result;
   logic         zero;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   alu_mdu #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .a           (a),
      .b           (b),
      .alucontrol  (alucontrol),
      .bne_flag    (bne_flag),
      .start       (start),
      .result      (result),
      .zero        (zero),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Combinational vectors
   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         bne;
      logic [W-1:0] res;
      logic         z;
   } vec_t;

   localparam int NV = 17;
   vec_t vt [NV];

   // Scoreboard of expected mult/div outcomes
   typedef struct {
      string        name;
      logic [W-1:0] ehi;
      logic [W-1:0] elo;
      logic         edbz;
   } exp_t;

   exp_t sb[$];

   function automatic exp_t mk(input string nm, input logic [W-1:0] h,
                               input logic [W-1:0] l, input logic d);
      exp_t e;
      e.name = nm;
      e.ehi  = h;
      e.elo  = l;
      e.edbz = d;
      return e;
   endfunction

   // Reference model built on the simulator's native arithmetic
   function automatic exp_t model(input string nm, input logic [3:0] op,
                                  input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t        e;
      longint      sx;
      longint      sy;
      longint      q;
      longint      r;
      logic [63:0] p;
      e.name = nm;
      e.edbz = 1'b0;
      e.ehi  = '0;
      e.elo  = '0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (op)
         OP_MULT: begin
            p = 64'(sx * sy);
            e.ehi = p[63:32];
            e.elo = p[31:0];
         end
         OP_MULTU: begin
            p = {32'h0, x} * {32'h0, y};
            e.ehi = p[63:32];
            e.elo = p[31:0];
         end
         OP_DIV, OP_DIVU: begin
            if (y == '0) begin
               e.ehi  = x;
               e.elo  = '1;
               e.edbz = 1'b1;
            end else if (op == OP_DIV) begin
               q = sx / sy;
               r = sx % sy;
               e.elo = 32'(q);
               e.ehi = 32'(r);
            end else begin
               e.elo = x / y;
               e.ehi = x % y;
            end
         end
         default: ;
      endcase
      return e;
   endfunction

   // Launch one mult/div, wait for done (bounded) and score HI/LO
   task automatic run_md(input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input exp_t e);
      int   cyc;
      int   bcyc;
      exp_t got;
      sb.push_back(e);
      @(negedge clk);
      alucontrol = op;
      a          = x;
      b          = y;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({e.name, "_busy_after_accept"}, 64'(busy), 64'd1);
      chk({e.name, "_dbz_cleared"}, 64'(div_by_zero), 64'd0);
      chk({e.name, "_result_zero"}, 64'(result), 64'd0);
      cyc  = 0;
      bcyc = 0;
      while (!done && cyc < 100) begin
         if (busy) bcyc++;
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({e.name, "_latency"}, 64'(cyc), 64'd33);
      chk({e.name, "_busy_cycles"}, 64'(bcyc), 64'd33);
      chk({e.name, "_busy_low_at_done"}, 64'(busy), 64'd0);
      got = sb.pop_front();
      chk({got.name, "_hi"}, 64'(hi), 64'(got.ehi));
      chk({got.name, "_lo"}, 64'(lo), 64'(got.elo));
      chk({got.name, "_dbz"}, 64'(div_by_zero), 64'(got.edbz));
   endtask

   // MTHI/MTLO: write on the accept edge, no busy/done
   task automatic run_mt(input logic [3:0] op, input logic [W-1:0] v);
      logic [W-1:0] old_hi;
      logic [W-1:0] old_lo;
      old_hi = hi;
      old_lo = lo;
      @(negedge clk);
      alucontrol = op;
      a          = v;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (op == OP_MTHI) begin
         chk("mthi_hi", 64'(hi), 64'(v));
         chk("mthi_lo_kept", 64'(lo), 64'(old_lo));
      end else begin
         chk("mtlo_lo", 64'(lo), 64'(v));
         chk("mtlo_hi_kept", 64'(hi), 64'(old_hi));
      end
      chk("mt_no_busy", 64'(busy), 64'd0);
      chk("mt_no_done", 64'(done), 64'd0);
   endtask

   initial begin
      int           cyc;
      int           dcnt;
      logic [3:0]   rop;
      logic [W-1:0] rx;
      logic [W-1:0] ry;

      vt[0]  = '{OP_ADD,  32'h0000_0007, 32'hFFFF_FFF9, 1'b0, 32'h0000_0000, 1'b1};
      vt[1]  = '{OP_ADD,  32'h0000_0007, 32'hFFFF_FFF9, 1'b1, 32'h0000_0000, 1'b0};
      vt[2]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0};
      vt[3]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
      vt[4]  = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 1'b0};
      vt[5]  = '{OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 32'hFFFF_FFFF, 1'b0};
      vt[6]  = '{OP_XOR,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000, 1'b1};
      vt[7]  = '{OP_NOR,  32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0};
      vt[8]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0};
      vt[9]  = '{OP_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
      vt[10] = '{OP_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0000_0001, 1'b0};
      vt[11] = '{OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b0};
      vt[12] = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
      vt[13] = '{OP_SLT,  32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0001, 1'b0};
      vt[14] = '{OP_MULT, 32'h1234_5678, 32'h0000_0002, 1'b0, 32'h0000_0000, 1'b1};
      vt[15] = '{OP_MFHI, 32'h1234_5678, 32'h0000_0002, 1'b1, 32'h0000_0000, 1'b0};
      vt[16] = '{OP_MTLO, 32'h1234_5678, 32'h0000_0002, 1'b0, 32'h0000_0000, 1'b1};

      reset_n    = 1'b0;
      a          = '0;
      b          = '0;
      alucontrol = OP_AND;
      bne_flag   = 1'b0;
      start      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dbz", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Combinational table (start held low, HI/LO still zero)
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         alucontrol = vt[i].op;
         a          = vt[i].va;
         b          = vt[i].vb;
         bne_flag   = vt[i].bne;
         #1;
         chk($sformatf("vec%0d_result", i), 64'(result), 64'(vt[i].res));
         chk($sformatf("vec%0d_zero", i), 64'(zero), 64'(vt[i].z));
      end
      bne_flag = 1'b0;
      @(posedge clk);
      #1;
      chk("table_no_busy", 64'(busy), 64'd0);
      chk("table_lo_untouched", 64'(lo), 64'd0);

      // Multiply/divide corner cases
      run_md(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, mk("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0));
      run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0));
      run_md(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, mk("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
      run_md(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, mk("div_min_m1", 32'h0000_0000, 32'h8000_0000, 1'b0));
      run_md(OP_DIVU,  32'h0000_0007, 32'h0000_0000, mk("divu_by0", 32'h0000_0007, 32'hFFFF_FFFF, 1'b1));
      // Back-to-back: accept while done is high; also clears div_by_zero
      chk("b2b_done_high", 64'(done), 64'd1);
      run_md(OP_MULTU, 32'h0000_0006, 32'h0000_0007, mk("multu_b2b", 32'h0000_0000, 32'h0000_002A, 1'b0));
      run_md(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, mk("div_neg_by0", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1));

      // Randomised mult/div against the native-arithmetic model
      for (int i = 0; i < 8; i++) begin
         rop = 4'(32'hA + $urandom_range(0, 3));
         rx  = $urandom;
         ry  = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 9));
         run_md(rop, rx, ry, model($sformatf("rand%0d_op%h", i, rop), rop, rx, ry));
      end

      // MTHI/MTLO and MFHI/MFLO readback
      run_mt(OP_MTLO, 32'h1234_5678);
      run_mt(OP_MTHI, 32'hDEAD_BEEF);
      @(negedge clk);
      alucontrol = OP_MFHI;
      #1;
      chk("mfhi_result", 64'(result), 64'h0000_0000_DEAD_BEEF);

      // Start/MTLO while busy are ignored; MFLO shows the previous value
      sb.push_back(mk("multu_busy_ignore", 32'h0000_0000, 32'h0000_000F, 1'b0));
      @(negedge clk);
      alucontrol = OP_MULTU;
      a          = 32'd3;
      b          = 32'd5;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      alucontrol = OP_DIVU;
      a          = 32'd100;
      b          = 32'd0;
      start      = 1'b1;
      @(posedge clk);
      #1;
      chk("ign_busy_e10", 64'(busy), 64'd1);
      alucontrol = OP_MTLO;
      a          = 32'h0000_AAAA;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("ign_mtlo_lo", 64'(lo), 64'h0000_0000_1234_5678);
      alucontrol = OP_MFLO;
      #1;
      chk("ign_mflo_result", 64'(result), 64'h0000_0000_1234_5678);
      alucontrol = OP_MFHI;
      #1;
      chk("ign_mfhi_result", 64'(result), 64'h0000_0000_DEAD_BEEF);
      cyc = 11;
      while (!done && cyc < 150) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("ign_latency", 64'(cyc), 64'd33);
      begin
         exp_t got;
         got = sb.pop_front();
         chk({got.name, "_hi"}, 64'(hi), 64'(got.ehi));
         chk({got.name, "_lo"}, 64'(lo), 64'(got.elo));
         chk({got.name, "_dbz"}, 64'(div_by_zero), 64'(got.edbz));
      end
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) dcnt++;
      end
      chk("ign_no_extra_done", 64'(dcnt), 64'd0);
      chk("ign_lo_stable", 64'(lo), 64'h0000_0000_0000_000F);

      // Reset in the middle of a multiply
      run_mt(OP_MTHI, 32'h0000_0055);
      @(negedge clk);
      alucontrol = OP_MULT;
      a          = 32'hFFFF_FFFD;
      b          = 32'h0000_0007;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_hi", 64'(hi), 64'd0);
      chk("midrst_lo", 64'(lo), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 45; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) dcnt++;
      end
      chk("midrst_no_done_after", 64'(dcnt), 64'd0);
      chk("midrst_lo_after", 64'(lo), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
